// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 slave scratch RAM of 2**ADDR_WIDTH bytes with independent
// read and write engines. Supports FIXED/INCR/WRAP bursts, narrow and unaligned
// transfers, and byte strobes.
// Optional build macro AXI_BURST_RAM_ERR_RESP_EN: when defined, illegal bursts
// are fully handshaked, never write memory, and answer with SLVERR.
module axi_burst_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int WORDS = 2 ** (ADDR_WIDTH - LSB);

`ifdef AXI_BURST_RAM_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0]            w_len, w_cnt, r_len, r_cnt;
    logic [2:0]            w_size, r_size;
    logic [1:0]            w_burst, r_burst;
    logic                  w_err;
    logic                  aw_hs, w_beat, ar_hs, r_beat, wlast_bad;

    // Address of the beat after 'addr'; all arithmetic wraps modulo the memory size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [31:0] a, nbytes, total, lower, nxt;
        logic        wrap_ok;
        a       = 32'(addr);
        nbytes  = 32'd1 << size;
        total   = nbytes * (32'(len) + 32'd1);
        lower   = a & ~(total - 32'd1);
        wrap_ok = (burst == 2'b10) &&
                  (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        nxt     = (a & ~(nbytes - 32'd1)) + nbytes;
        if (burst == 2'b00) begin
            nxt = a;
        end else if (wrap_ok) begin
            nxt = a + nbytes;
            if (nxt == lower + total) nxt = lower;
        end
        return nxt[ADDR_WIDTH-1:0];
    endfunction

    // Burst parameters that the error-response build refuses to service.
    function automatic logic is_illegal(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [1:0] burst);
        logic        bad;
        logic [31:0] mask;
        bad  = 1'b0;
        mask = (32'd1 << size) - 32'd1;
        if (burst == 2'b11) bad = 1'b1;
        if (int'(size) > LSB) bad = 1'b1;
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
            if ((32'(addr) & mask) != 32'd0) bad = 1'b1;
        end
        return bad;
    endfunction

    assign aw_hs     = (w_state == W_IDLE) && awvalid;
    assign w_beat    = (w_state == W_DATA) && wvalid;
    assign ar_hs     = (r_state == R_IDLE) && arvalid;
    assign r_beat    = (r_state == R_DATA) && rready;
    assign wlast_bad = ERR_EN && (wlast != (w_cnt == 8'd0));
    assign bresp     = w_err ? 2'b10 : 2'b00;

    // Write engine state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write engine next state and handshake outputs; the beat count ends the burst.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_cnt == 8'd0) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latch on AW, advance address and count per beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_cnt   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_err   <= ERR_EN && is_illegal(awaddr, awlen, awsize, awburst);
        end else if (w_beat) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt - 8'd1;
            if (wlast_bad) w_err <= 1'b1;
        end
    end

    // Memory byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (w_beat && !w_err && !wlast_bad) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[w_addr[ADDR_WIDTH-1:LSB]][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read engine state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read engine next state and handshake outputs.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Registered read data: load the first word on AR, the next word on each accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (ar_hs) begin
            rdata   <= mem[araddr[ADDR_WIDTH-1:LSB]];
            rresp   <= (ERR_EN && is_illegal(araddr, arlen, arsize, arburst)) ? 2'b10 : 2'b00;
            rlast   <= (arlen == 8'd0);
            r_addr  <= next_addr(araddr, arlen, arsize, arburst);
            r_len   <= arlen;
            r_cnt   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
        end else if (r_beat) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                rdata  <= mem[r_addr[ADDR_WIDTH-1:LSB]];
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt  <= r_cnt - 8'd1;
                rlast  <= (r_cnt == 8'd1);
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: directed self-checking bench for axi_burst_ram (32-bit bus,
// 1 KiB). Define AXI_BURST_RAM_ERR_RESP_EN for both files to add the SLVERR cases.
module tb_axi_burst_ram;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;

    logic          aclk;
    logic          aresetn;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] exp_data[16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];

    axi_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // 100 MHz clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Full write burst from wr_data/wr_strb, checking handshake timing and response
    task automatic writeBurst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [1:0] exp_bresp);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        checkOutput("awready_idle", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        checkOutput("wready_after_aw", 32'(wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wr_data[i];
            wstrb  = wr_strb[i];
            wlast  = (i == int'(len));
            wvalid = 1'b1;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        checkOutput("bvalid_after_last", 32'(bvalid), 32'd1);
        checkOutput("bresp", 32'(bresp), 32'(exp_bresp));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        checkOutput("bvalid_clear", 32'(bvalid), 32'd0);
    endtask

    // Full read burst into rd_*; optional rready toggling verifies rdata holds while stalled
    task automatic readBurst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic stall);
        int          beat;
        int          cycles;
        logic        stalled;
        logic [31:0] held;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        checkOutput("arready_idle", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        checkOutput("rvalid_after_ar", 32'(rvalid), 32'd1);
        beat = 0; cycles = 0; stalled = 1'b0; held = '0;
        while (beat <= int'(len) && cycles < 200) begin
            if (stalled) checkOutput("rdata_hold", rdata, held);
            rready  = stall ? ((cycles % 2) == 0) : 1'b1;
            stalled = 1'b0;
            if (rvalid && rready) begin
                rd_data[beat] = rdata;
                rd_last[beat] = rlast;
                rd_resp[beat] = rresp;
                beat++;
            end else if (rvalid) begin
                stalled = 1'b1;
                held    = rdata;
            end
            @(posedge aclk); #1;
            cycles++;
        end
        rready = 1'b0;
        checkOutput("read_beat_count", 32'(beat), 32'(int'(len) + 1));
        checkOutput("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    // Compare captured read beats against exp_data, rlast only on the final beat
    task automatic checkBeats(input int n, input logic [1:0] exp_resp);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("rdata[%0d]", i), rd_data[i], exp_data[i]);
            checkOutput($sformatf("rlast[%0d]", i), 32'(rd_last[i]), 32'(i == n - 1));
            checkOutput($sformatf("rresp[%0d]", i), 32'(rd_resp[i]), 32'(exp_resp));
        end
    endtask

    // Directed test sequence
    task automatic applyStimulus();
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_awready", 32'(awready), 32'd1);
        checkOutput("rst_arready", 32'(arready), 32'd1);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rlast", 32'(rlast), 32'd0);
        checkOutput("rst_bresp", 32'(bresp), 32'd0);
        checkOutput("rst_rresp", 32'(rresp), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        $display("[TB] INCR write/read at 0x10");
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; exp_data[i] = 32'hA0 + 32'(i);
        end
        writeBurst(10'h010, 8'd3, 3'd2, 2'd1, 2'b00);
        readBurst(10'h010, 8'd3, 3'd2, 2'd1, 1'b0);
        checkBeats(4, 2'b00);

        $display("[TB] WRAP read from 0x38");
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hB0 + 32'(i); wr_strb[i] = 4'hF;
        end
        writeBurst(10'h030, 8'd3, 3'd2, 2'd1, 2'b00);
        exp_data[0] = 32'hB2; exp_data[1] = 32'hB3; exp_data[2] = 32'hB0; exp_data[3] = 32'hB1;
        readBurst(10'h038, 8'd3, 3'd2, 2'd2, 1'b0);
        checkBeats(4, 2'b00);

        $display("[TB] WRAP write from 0x48");
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hC0 + 32'(i); wr_strb[i] = 4'hF;
        end
        writeBurst(10'h048, 8'd3, 3'd2, 2'd2, 2'b00);
        exp_data[0] = 32'hC2; exp_data[1] = 32'hC3; exp_data[2] = 32'hC0; exp_data[3] = 32'hC1;
        readBurst(10'h040, 8'd3, 3'd2, 2'd1, 1'b0);
        checkBeats(4, 2'b00);

        $display("[TB] FIXED strobed write to 0x20");
        wr_data[0] = 32'h0000_0011; wr_strb[0] = 4'h1;
        wr_data[1] = 32'h0000_2200; wr_strb[1] = 4'h2;
        wr_data[2] = 32'h0033_0000; wr_strb[2] = 4'h4;
        wr_data[3] = 32'h4400_0000; wr_strb[3] = 4'h8;
        writeBurst(10'h020, 8'd3, 3'd2, 2'd0, 2'b00);
        exp_data[0] = 32'h4433_2211; exp_data[1] = 32'h4433_2211;
        readBurst(10'h020, 8'd1, 3'd2, 2'd0, 1'b0);
        checkBeats(2, 2'b00);

        $display("[TB] narrow byte INCR from 0x61");
        wr_data[0] = 32'h0000_00EE; wr_strb[0] = 4'hF;
        writeBurst(10'h060, 8'd0, 3'd2, 2'd0, 2'b00);
        wr_data[0] = 32'h0000_1100; wr_strb[0] = 4'h2;
        wr_data[1] = 32'h0022_0000; wr_strb[1] = 4'h4;
        wr_data[2] = 32'h3300_0000; wr_strb[2] = 4'h8;
        writeBurst(10'h061, 8'd2, 3'd0, 2'd1, 2'b00);
        exp_data[0] = 32'h3322_11EE;
        readBurst(10'h060, 8'd0, 3'd2, 2'd1, 1'b0);
        checkBeats(1, 2'b00);

        $display("[TB] unaligned INCR from 0x72");
        wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
        writeBurst(10'h070, 8'd0, 3'd2, 2'd0, 2'b00);
        wr_data[0] = 32'h5555_AAAA; wr_strb[0] = 4'hC;
        wr_data[1] = 32'h1234_5678; wr_strb[1] = 4'hF;
        writeBurst(10'h072, 8'd1, 3'd2, 2'd1, 2'b00);
        exp_data[0] = 32'h5555_0000; exp_data[1] = 32'h1234_5678;
        readBurst(10'h070, 8'd1, 3'd2, 2'd1, 1'b0);
        checkBeats(2, 2'b00);

        $display("[TB] 8-beat read with rready toggling");
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = 32'hD000_0000 | 32'(i * 17); wr_strb[i] = 4'hF;
            exp_data[i] = 32'hD000_0000 | 32'(i * 17);
        end
        writeBurst(10'h080, 8'd7, 3'd2, 2'd1, 2'b00);
        readBurst(10'h080, 8'd7, 3'd2, 2'd1, 1'b1);
        checkBeats(8, 2'b00);

        $display("[TB] reset in the middle of a write burst");
        awaddr = 10'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wdata = 32'hDEAD_0000; wstrb = 4'hF; wvalid = 1'b1; wlast = 1'b0;
        repeat (2) begin
            @(posedge aclk); #1;
        end
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_awready", 32'(awready), 32'd1);
        checkOutput("midrst_wready", 32'(wready), 32'd0);
        checkOutput("midrst_bvalid", 32'(bvalid), 32'd0);
        wvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'hE0 + 32'(i); wr_strb[i] = 4'hF; exp_data[i] = 32'hE0 + 32'(i);
        end
        writeBurst(10'h100, 8'd3, 3'd2, 2'd1, 2'b00);
        readBurst(10'h100, 8'd3, 3'd2, 2'd1, 1'b0);
        checkBeats(4, 2'b00);

`ifdef AXI_BURST_RAM_ERR_RESP_EN
        $display("[TB] SLVERR: reserved burst type read");
        readBurst(10'h010, 8'd1, 3'd2, 2'd3, 1'b0);
        checkOutput("err_rresp0", 32'(rd_resp[0]), 32'd2);
        checkOutput("err_rresp1", 32'(rd_resp[1]), 32'd2);
        checkOutput("err_rlast1", 32'(rd_last[1]), 32'd1);

        $display("[TB] SLVERR: oversized write leaves memory untouched");
        wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
        writeBurst(10'h010, 8'd0, 3'd3, 2'd1, 2'b10);
        exp_data[0] = 32'hA0;
        readBurst(10'h010, 8'd0, 3'd2, 2'd1, 1'b0);
        checkBeats(1, 2'b00);
`endif
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung handshake
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram
Overview: Parametrised AXI4 slave RAM with independent, concurrently operating read and write engines. Supports FIXED, INCR and WRAP bursts, narrow and unaligned transfers, and byte strobes. Sits behind the interconnect as a byte-addressed test/scratch memory of 2**ADDR_WIDTH bytes.
Parameters:
DATA_WIDTH, 32, data bus width in bits; power of two, 8..1024
ADDR_WIDTH, 10, byte address width; memory depth 2**ADDR_WIDTH bytes
STRB_WIDTH, DATA_WIDTH/8, bytes per word (BYTES); derived, never overridden
Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
awaddr  in  ADDR_WIDTH  write burst start byte address
awlen  in  8  write beats minus 1
awsize  in  3  log2 bytes per write beat
awburst  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  STRB_WIDTH  byte-lane write enables
wlast  in  1  last write beat marker
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read burst start byte address
arlen  in  8  read beats minus 1
arsize  in  3  log2 bytes per read beat
arburst  in  2  read burst type
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  read data valid
rready  in  1  read data ready
Behaviour:
- Reset (async, aresetn=0): write FSM->W_IDLE, read FSM->R_IDLE; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0 (OKAY), rdata=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Write FSM: W_IDLE (awready=1) -> on awvalid&&awready latch addr/len/size/burst, beat count=awlen+1 -> W_DATA (wready=1). Each wvalid&&wready writes the lanes with wstrb set into word addr>>log2(BYTES) at the edge. Last counted beat -> W_RESP (bvalid=1, bresp=OKAY) -> on bready -> W_IDLE. Burst termination follows the beat count; wlast does not terminate. AW->W latency 1 cycle; last W->bvalid 1 cycle.
- Read FSM: R_IDLE (arready=1) -> on handshake latch params -> R_DATA. rvalid and rdata are registered: rvalid rises 1 cycle after AR; each rvalid&&rready loads the next beat's word on the same edge (back-to-back, 1 beat/cycle). rlast=1 on the final beat. Final beat accepted -> R_IDLE, rvalid=0. rdata is held stable while rvalid&&!rready.
- Address generation (both engines, ADDR_WIDTH-bit, modulo 2**ADDR_WIDTH): nbytes=2**size; aligned=addr&~(nbytes-1). First beat uses start addr. FIXED: every beat uses start addr. INCR: beat n = aligned + n*nbytes. WRAP: total=nbytes*(len+1), lower=addr&~(total-1); next=addr+nbytes, and if next==lower+total then next=lower. Rdata always returns the full word; the master selects lanes.
- Simultaneous read and write to the same word: the read beat loaded on that edge returns pre-write data.
- Without the optional feature, size>log2(BYTES), WRAP with len not in {1,3,7,15}, and awburst/arburst=3 are unchecked and treated as INCR.
Optional Feature:
AXI_BURST_RAM_ERR_RESP_EN: when defined, an illegal burst is still fully handshaked with no memory writes, and returns bresp=SLVERR(2'b10) or rresp=SLVERR on every beat. Illegal bursts are: burst=3; size>log2(BYTES); WRAP with unaligned addr or len not in {1,3,7,15}; a wlast position mismatching the beat count. When undefined, responses are always OKAY and the rules above apply.
Test Plan:
- INCR write awaddr=0x10,len=3,size=2, data 0xA0..0xA3, wstrb=F -> bvalid 1 cycle after last beat, bresp=0; INCR read of same -> 0xA0..0xA3, rlast on 4th beat.
- WRAP read araddr=0x38,len=3,size=2 -> beat addresses 0x38,0x3C,0x30,0x34.
- FIXED write 4 beats to 0x20 with wstrb 1,2,4,8 and data 0x11,0x2200,0x330000,0x44000000 -> read 0x20 returns 0x44332211.
- rready toggled 1/0 every cycle during an 8-beat read -> rdata held stable while stalled, all 8 beats delivered in order.
- aresetn pulsed low mid 4-beat write -> awready=1, wready=0, bvalid=0 immediately; a new burst then completes normally.
- ERR_RESP_EN: arburst=3 len=1 -> 2 beats, rresp=2'b10; awsize=3 on 32-bit bus -> memory unchanged, bresp=2'b10.
